// File: rtl/uart_tx_fifo.sv
// Byte FIFO and launch sequencer feeding a UART transmitter via a launch/done handshake.
// Optional sticky overflow flag enabled by defining UART_TX_FIFO_OVERFLOW_EN.
module uart_tx_fifo #(
    parameter int unsigned DEPTH = 16,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    input  logic              tx_busy,
    input  logic              tx_done,
    output logic              tx_enabled,
    output logic [7:0]        tx_in,
    output logic              overflow,
    input  logic              ovf_clr
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LAUNCH = 2'd1;
    localparam logic [1:0] WAIT   = 2'd2;

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count_q;
    logic [1:0]        state_q;
    logic [1:0]        state_d;
    logic [7:0]        tx_in_q;
    logic              push;
    logic              pop;

    assign count      = count_q;
    assign full       = (count_q == FULL_CNT);
    assign empty      = (count_q == '0);
    assign tx_enabled = (state_q == LAUNCH);
    assign tx_in      = tx_in_q;

    // full is the pre-pop value, so a write while full is refused even on a pop edge
    assign push = wr_en && !full;
    assign pop  = (state_q == IDLE) && !empty;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (!empty) state_d = LAUNCH;
            LAUNCH:  state_d = WAIT;
            WAIT:    if (tx_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or posedge rstN) begin
        if (rstN) begin
            state_q <= IDLE;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            tx_in_q <= 8'h00;
        end else begin
            state_q <= state_d;
            if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (pop) begin
                rd_ptr  <= rd_ptr + ADDR_W'(1);
                tx_in_q <= mem[rd_ptr];
            end
            if (push && !pop) begin
                count_q <= count_q + (ADDR_W + 1)'(1);
            end else if (pop && !push) begin
                count_q <= count_q - (ADDR_W + 1)'(1);
            end
        end
    end

`ifdef UART_TX_FIFO_OVERFLOW_EN
    logic ovf_q;
    logic unused_in;

    // set takes priority over clear on the same edge
    always_ff @(posedge clk or posedge rstN) begin
        if (rstN) begin
            ovf_q <= 1'b0;
        end else if (wr_en && full) begin
            ovf_q <= 1'b1;
        end else if (ovf_clr) begin
            ovf_q <= 1'b0;
        end
    end

    assign overflow  = ovf_q;
    assign unused_in = tx_busy;
`else
    logic unused_in;

    assign overflow  = 1'b0;
    assign unused_in = tx_busy ^ ovf_clr;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed self-checking bench for uart_tx_fifo: latency, burst ordering, full/overflow,
// pointer wrap, simultaneous write+pop and mid-frame reset.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rstN;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_enabled;
    logic [7:0] tx_in;
    logic       overflow;
    logic       ovf_clr;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

`ifdef UART_TX_FIFO_OVERFLOW_EN
    localparam logic OVF_EN = 1'b1;
`else
    localparam logic OVF_EN = 1'b0;
`endif

    uart_tx_fifo #(.DEPTH(16)) dut (
        .clk        (clk),
        .rstN       (rstN),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .tx_enabled (tx_enabled),
        .tx_in      (tx_in),
        .overflow   (overflow),
        .ovf_clr    (ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_count"}, count, 0);
        chk({tag, "_empty"}, empty, 1);
        chk({tag, "_full"}, full, 0);
        chk({tag, "_txen"}, tx_enabled, 0);
        chk({tag, "_txin"}, tx_in, 8'h00);
        chk({tag, "_ovf"}, overflow, 0);
    endtask

    // Host writes nwr bytes (respecting full), transmitter model returns tx_done dly cycles
    // after each launch; checks launch data order, 2-cycle done-to-launch gap and count.
    task automatic stream(input int nwr, input logic [7:0] wbase, input int nl,
                          input logic [7:0] ebase, input int dly, input bit pend,
                          input int init_cnt);
        int widx = 0;
        int n = 0;
        int done_at;
        int last_done = -1;
        int model = init_cnt;
        int guard = 0;
        bit pending = pend;
        bit done_now;
        bit wacc;
        bit prev_en = 1'b0;
        done_at = cyc;
        while (!(n == nl && !pending && widx == nwr) && guard < 3000) begin
            wr_en    = (widx < nwr) && !full;
            wr_data  = wbase + 8'(widx);
            done_now = pending && (cyc >= done_at);
            tx_done  = done_now;
            wacc     = wr_en;
            step();
            if (wacc) begin
                widx++;
                model++;
            end
            if (done_now) begin
                pending   = 1'b0;
                last_done = cyc - 1;
            end
            if (tx_enabled) begin
                model--;
                chk("launch_data", tx_in, ebase + 8'(n));
                chk("no_double_pulse", prev_en, 0);
                if (last_done >= 0) chk("done_to_launch_gap", cyc - last_done, 2);
                n++;
                pending = 1'b1;
                done_at = cyc + dly;
            end
            prev_en = tx_enabled;
            chk("count_model", count, model);
            guard++;
        end
        wr_en   = 1'b0;
        tx_done = 1'b0;
        chk("launches", n, nl);
    endtask

    initial begin
        rstN    = 1'b1;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        tx_busy = 1'b0;
        tx_done = 1'b0;
        ovf_clr = 1'b0;
        step();
        step();
        chk_reset_state("reset");
        rstN = 1'b0;
        step();

        // Single byte latency
        wr_en   = 1'b1;
        wr_data = 8'hA5;
        step();
        wr_en = 1'b0;
        chk("single_count1", count, 1);
        chk("single_empty0", empty, 0);
        chk("single_txen_early", tx_enabled, 0);
        step();
        chk("single_txen", tx_enabled, 1);
        chk("single_txin", tx_in, 8'hA5);
        chk("single_count0", count, 0);
        step();
        chk("single_pulse_end", tx_enabled, 0);
        chk("single_txin_hold", tx_in, 8'hA5);
        step();
        step();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        step();
        chk("single_idle_txen", tx_enabled, 0);
        chk("single_empty1", empty, 1);

        // Burst of five, done 20 cycles after each launch
        stream(5, 8'h01, 5, 8'h01, 20, 1'b0, 0);
        chk("burst_empty", empty, 1);

        // Fill to full with no tx_done; 18th write dropped
        for (int i = 0; i < 18; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'h10 + 8'(i);
            step();
        end
        wr_en = 1'b0;
        chk("full_count", count, 16);
        chk("full_flag", full, 1);
        chk("full_empty", empty, 0);
        chk("full_txin", tx_in, 8'h10);
        chk("ovf_set", overflow, OVF_EN);
        wr_en   = 1'b1;
        wr_data = 8'h22;
        ovf_clr = 1'b1;
        step();
        wr_en = 1'b0;
        chk("ovf_set_wins", overflow, OVF_EN);
        chk("full_count_hold", count, 16);
        step();
        ovf_clr = 1'b0;
        chk("ovf_cleared", overflow, 0);
        stream(0, 8'h00, 16, 8'h11, 2, 1'b1, 16);
        chk("drain_empty", empty, 1);

        // Pointer wrap: 40 bytes through the 16-entry FIFO
        stream(40, 8'h40, 40, 8'h40, 3, 1'b0, 0);
        chk("wrap_empty", empty, 1);

        // Write on the same edge as an IDLE->LAUNCH pop with count = 3
        for (int i = 0; i < 4; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'h61 + 8'(i);
            step();
        end
        wr_en = 1'b0;
        chk("simul_pre_count", count, 3);
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        chk("simul_idle_count", count, 3);
        wr_en   = 1'b1;
        wr_data = 8'h65;
        step();
        wr_en = 1'b0;
        chk("simul_count", count, 3);
        chk("simul_txen", tx_enabled, 1);
        chk("simul_txin", tx_in, 8'h62);
        step();
        chk("simul_wait", tx_enabled, 0);
        stream(0, 8'h00, 3, 8'h63, 2, 1'b1, 3);

        // Reset while waiting for tx_done with 4 bytes queued
        for (int i = 0; i < 5; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'h71 + 8'(i);
            step();
        end
        wr_en = 1'b0;
        chk("rst_pre_count", count, 4);
        rstN = 1'b1;
        step();
        step();
        chk_reset_state("midrst");
        rstN    = 1'b0;
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        chk("rst_done_ignored", tx_enabled, 0);
        step();
        step();
        chk("rst_no_launch", tx_enabled, 0);
        chk("rst_still_empty", empty, 1);
        wr_en   = 1'b1;
        wr_data = 8'h3C;
        step();
        wr_en = 1'b0;
        chk("rst_new_count", count, 1);
        chk("rst_new_txen_early", tx_enabled, 0);
        step();
        chk("rst_new_txen", tx_enabled, 1);
        chk("rst_new_txin", tx_in, 8'h3C);
        step();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        step();
        chk("final_empty", empty, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
